// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for uart_tx.
// master drives the request side, slave (the transmitter) drives the line and status.
interface uart_tx_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       tx_done;
  logic       busy;

  modport master (output trmt, output tx_data, input TX, input tx_done, input busy);
  modport slave  (input trmt, input tx_data, output TX, output tx_done, output busy);
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, start + d0..d7 (+ even parity) + stop, BAUD_DIV clocks per bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between d7 and stop.
module uart_tx #(
  parameter int BAUD_DIV = 108
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic {IDLE, TXING} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [FRAME_BITS-2:0]   r_shift;
  logic [6:0]              r_baud;
  logic [3:0]              r_bit;
  logic                    r_tx;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_wrap;
  logic                    w_last;
  logic [FRAME_BITS-1:0]   w_frame;

`ifdef UART_TX_PARITY_EN
  assign w_frame = {1'b1, ^bus.tx_data, bus.tx_data, 1'b0};
`else
  assign w_frame = {1'b1, bus.tx_data, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wrap       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = bus.trmt;
        if (bus.trmt) w_state_next = TXING;
      end
      TXING: begin
        w_wrap = (r_baud == 7'(BAUD_DIV - 1));
        w_last = w_wrap && (r_bit == 4'(FRAME_BITS - 1));
        if (w_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (r_state == TXING);
    bus.TX      = r_tx;
    bus.tx_done = r_done;
  end

  // Frame bit 0 is already on the line in r_tx; r_shift holds the bits still to send.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_baud  <= 7'd0;
      r_bit   <= 4'd0;
      r_shift <= '1;
    end else if (w_accept) begin
      r_shift <= w_frame[FRAME_BITS-1:1];
      r_tx    <= w_frame[0];
      r_baud  <= 7'd0;
      r_bit   <= 4'd0;
      r_done  <= 1'b0;
    end else if (r_state == TXING) begin
      if (w_wrap) begin
        r_shift <= {1'b1, r_shift[FRAME_BITS-2:1]};
        r_bit   <= r_bit + 4'd1;
        r_baud  <= 7'd0;
        if (w_last) begin
          r_tx   <= 1'b1;
          r_done <= 1'b1;
        end else begin
          r_tx   <= r_shift[0];
        end
      end else begin
        r_baud <= r_baud + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: idle after reset, frame timing/content, ignored requests,
// back-to-back frames, mid-frame reset, and parity frames when UART_TX_PARITY_EN is set.
module tb_uart_tx;
  localparam int B = 108;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  uart_tx_if bus ();

  uart_tx #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one byte and checks every cycle of the frame; exp_bits[i] is the i-th bit on the line.
  task automatic send_frame(input logic [7:0] data, input logic [FB-1:0] exp_bits,
                            input int inject_at, input string tag);
    logic       bit_ok;
    logic       early_done;
    logic [7:0] rx;
    int         busy_cnt;
    int         k;
    bus.trmt    = 1'b1;
    bus.tx_data = data;
    tick();
    bus.trmt    = 1'b0;
    bus.tx_data = ~data;
    check({tag, " accept clears tx_done"}, bus.tx_done, 1'b0);
    busy_cnt   = 0;
    early_done = 1'b0;
    rx         = 8'h00;
    for (int b = 0; b < FB; b++) begin
      bit_ok = 1'b1;
      for (int c = 0; c < B; c++) begin
        k = b * B + c;
        if (k == inject_at) begin
          bus.trmt    = 1'b1;
          bus.tx_data = 8'hFF;
        end else begin
          bus.trmt    = 1'b0;
        end
        if (bus.TX !== exp_bits[b]) bit_ok = 1'b0;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.tx_done !== 1'b0) early_done = 1'b1;
        if (c == B / 2 && b >= 1 && b <= 8) rx[b-1] = bus.TX;
        tick();
      end
      check($sformatf("%s bit %0d", tag, b), bit_ok, 1'b1);
    end
    bus.trmt = 1'b0;
    check({tag, " no early tx_done"}, early_done, 1'b0);
    check({tag, " tx_done at frame end"}, bus.tx_done, 1'b1);
    check({tag, " busy low at end"}, bus.busy, 1'b0);
    check({tag, " TX idle at end"}, bus.TX, 1'b1);
    check({tag, " busy cycles"}, busy_cnt, FB * B);
    check({tag, " received byte"}, rx, data);
    $display("[TB] frame %s data=%02h busy_cycles=%0d rx=%02h", tag, data, busy_cnt, rx);
  endtask

  initial begin
    logic idle_bad;
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;

    rst = 1'b1;
    tick();
    tick();
    check("reset TX", bus.TX, 1'b1);
    check("reset tx_done", bus.tx_done, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    rst = 1'b0;
    idle_bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.TX !== 1'b1 || bus.tx_done !== 1'b0 || bus.busy !== 1'b0) idle_bad = 1'b1;
    end
    check("idle 500 cycles", idle_bad, 1'b0);
    $display("[TB] idle 500 cycles after reset, bad=%0b", idle_bad);

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, 11'b11000001110, -1, "par07");
    tick();
    send_frame(8'h03, 11'b10000000110, -1, "par03");
    tick();
`else
    send_frame(8'hA5, 10'b1101001010, -1, "A5");
    tick();
    tick();
    send_frame(8'h3C, 10'b1001111000, 300, "3C_ignoreFF");
    tick();
    send_frame(8'h00, 10'b1000000000, -1, "b2b_00");
    send_frame(8'hFF, 10'b1111111110, -1, "b2b_FF");
    tick();
`endif

    // Mid-frame reset: abort the frame and make sure nothing completes.
    bus.trmt    = 1'b1;
    bus.tx_data = 8'h55;
    tick();
    bus.trmt    = 1'b0;
    repeat (500) tick();
    check("midframe busy before rst", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort TX", bus.TX, 1'b1);
    check("abort busy", bus.busy, 1'b0);
    check("abort tx_done", bus.tx_done, 1'b0);
    idle_bad = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (bus.TX !== 1'b1 || bus.tx_done !== 1'b0 || bus.busy !== 1'b0) idle_bad = 1'b1;
    end
    check("after abort quiet", idle_bad, 1'b0);
    $display("[TB] reset at cycle 500 of frame 55, quiet_bad=%0b", idle_bad);

    // Reset wins over a simultaneous request.
    rst         = 1'b1;
    bus.trmt    = 1'b1;
    bus.tx_data = 8'h55;
    tick();
    rst      = 1'b0;
    bus.trmt = 1'b0;
    check("rst over trmt busy", bus.busy, 1'b0);
    check("rst over trmt TX", bus.TX, 1'b1);
    tick();
    check("rst over trmt still idle", bus.busy, 1'b0);
    $display("[TB] rst with trmt same cycle, busy=%0b", bus.busy);

`ifdef UART_TX_PARITY_EN
    send_frame(8'h55, 11'b10010101010, -1, "55_after_abort");
`else
    send_frame(8'h55, 10'b1010101010, -1, "55_after_abort");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: BAUD_DIV, default 108, clocks per serial bit; legal range 4..127.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 trmt  input  1  single-cycle request to start transmitting tx_data.
REQ-005 tx_data  input  8  byte to send; sampled only on the edge that accepts trmt.
REQ-006 TX  output  1  serial line; idle high; registered output.
REQ-007 tx_done  output  1  high from the end of a frame until the next accepted trmt.
REQ-008 busy  output  1  high while a frame is in progress.

Function
REQ-009 The FSM SHALL have states IDLE and TXING; reset state is IDLE.
REQ-010 In IDLE with trmt=1, the block SHALL load the frame shift register as {1'b1 stop, tx_data, 1'b0 start}, clear the baud and bit counters and tx_done, and go to TXING on the same edge.
REQ-011 TX SHALL drive shift-register bit 0 from the clock edge that accepts trmt, so the start bit appears one cycle after trmt is sampled.
REQ-012 Data SHALL go out LSB first: start, d0..d7, stop.
REQ-013 Baud counter: 7 bits, counts 0..BAUD_DIV-1 in TXING.
  - At BAUD_DIV-1: shift the register right with 1 filled in, increment the bit counter, wrap the baud counter to 0.
  - Each bit SHALL last exactly BAUD_DIV cycles.
REQ-014 Frame end: on the shift that makes the bit counter equal 10 (frame length, see REQ-024), the FSM SHALL return to IDLE, set tx_done, and hold TX=1.
  - Frame length is 10*BAUD_DIV cycles, measured from the trmt edge to the tx_done edge.
REQ-015 busy SHALL equal (state==TXING).
REQ-016 trmt during TXING SHALL be ignored; tx_data and the frame in flight are unaffected.
REQ-017 tx_done SHALL stay high in IDLE until a trmt is accepted. That acceptance clears it on the same edge that starts the new frame.
REQ-018 A trmt that arrives in the first IDLE cycle after tx_done sets SHALL start a frame back-to-back. The next start bit then begins 1 cycle after the stop bit ends.
REQ-019 TX SHALL never glitch: it changes only on baud-counter wrap or on frame load.

Reset
REQ-020 rst=1 SHALL, on the next clock edge, force: state=IDLE, TX=1, tx_done=0, busy=0, baud counter=0, bit counter=0.
REQ-021 rst during TXING SHALL abort the frame. TX returns high on that edge and no tx_done is produced for the aborted frame.
REQ-022 rst takes priority over trmt in the same cycle.

Configuration
REQ-023 Macro UART_TX_PARITY_EN selects parity.
  - Defined: an even-parity bit (XOR of tx_data) is inserted between d7 and stop.
  - Undefined: no parity bit.
REQ-024 Frame length in bits, used as the bit-counter terminal value:
  - Parity defined: 11 bits, 11*BAUD_DIV cycles.
  - Parity undefined: 10 bits, 10*BAUD_DIV cycles; the line format is 8N1, compatible with the team's uart_rx.

Verification
REQ-025 Reset release, no trmt for 500 cycles -> TX=1, tx_done=0, busy=0 throughout.
REQ-026 BAUD_DIV=108, trmt with tx_data=8'hA5 -> TX bits 0,1,0,1,0,0,1,0,1,1, each 108 cycles; tx_done rises exactly 1080 cycles after the trmt edge.
REQ-027 trmt with 8'h3C, second trmt with 8'hFF at cycle 300 -> second request ignored; line carries 8'h3C only; busy high for 1080 cycles.
REQ-028 Back-to-back 8'h00 then 8'hFF, second trmt in the cycle after tx_done -> two contiguous frames; tx_done drops on the second accept; uart_rx in loopback reports both bytes.
REQ-029 rst asserted at cycle 500 of a frame of 8'h55 -> TX=1 on the next edge, busy=0, tx_done stays 0; a subsequent trmt of 8'h55 completes normally.
REQ-030 With UART_TX_PARITY_EN, send 8'h07 -> parity bit 1, frame 11 bits; send 8'h03 -> parity bit 0; tx_done at 1188 cycles.
